// File: rtl/stage4_alu_seq.sv
// Sequential multi-byte ALU stage: reads byte operands from the register file through one
// synchronous read port, writes one result byte per iteration and reports carry/zero/error.
// Optional feature macro STAGE4_ALU_SHIFT_EN enables SHL (opcode 6) and SHR (opcode 7).
module stage4_alu_seq #(
  parameter int unsigned REG_COUNT = 64,
  parameter int unsigned REG_AW    = 6,
  parameter int unsigned LEN_W     = 7
) (
  input  logic              ram_clk,
  input  logic              rst,
  input  logic              stage4_exec,
  output logic              stage4_exec_ready,
  input  logic [4:0]        stage4_oper,
  input  logic [REG_AW-1:0] stage4_src_a,
  input  logic [REG_AW-1:0] stage4_src_b,
  input  logic [REG_AW-1:0] stage4_dst,
  input  logic [LEN_W-1:0]  stage4_length,
  output logic [REG_AW-1:0] reg_read_address,
  input  logic [7:0]        reg_read_data,
  output logic              reg_write,
  output logic [REG_AW-1:0] reg_write_address,
  output logic [7:0]        reg_write_data,
  output logic              stage4_carry,
  output logic              stage4_zero,
  output logic              stage4_error
);

  localparam logic [4:0] OpAdd = 5'd1;
  localparam logic [4:0] OpSub = 5'd2;
  localparam logic [4:0] OpAnd = 5'd3;
  localparam logic [4:0] OpOr  = 5'd4;
  localparam logic [4:0] OpXor = 5'd5;
`ifdef STAGE4_ALU_SHIFT_EN
  localparam logic [4:0] OpShl = 5'd6;
  localparam logic [4:0] OpShr = 5'd7;
`endif

  // Index arithmetic relies on natural REG_AW-bit wrap, so the depth must match.
  if (REG_COUNT != (32'd1 << REG_AW)) begin : g_bad_cfg
    $error("REG_COUNT must equal 2**REG_AW");
  end

  typedef enum logic [2:0] {StIdle, StRdA, StRdB, StWr, StDone} state_e;

  state_e            r_state, w_state_next;
  logic              r_exec_q;
  logic [4:0]        r_oper;
  logic [REG_AW-1:0] r_src_a, r_src_b, r_dst, r_idx;
  logic [LEN_W-1:0]  r_cnt;
  logic [7:0]        r_a;
  logic              r_carry, r_zero, r_error, r_ready;

  logic              w_start, w_legal, w_is_shift, w_desc, w_last;
  logic [7:0]        w_a, w_res;
  logic [8:0]        w_sum;
  logic              w_cout;

  assign w_start = stage4_exec & ~r_exec_q & (r_state == StIdle);
  assign w_last  = (r_cnt == LEN_W'(1));

`ifdef STAGE4_ALU_SHIFT_EN
  assign w_is_shift = (r_oper == OpShl) || (r_oper == OpShr);
  assign w_desc     = (r_oper == OpShr);
`else
  assign w_is_shift = 1'b0;
  assign w_desc     = 1'b0;
`endif

  // Opcode legality of the incoming request.
  always_comb begin
    w_legal = 1'b0;
    case (stage4_oper)
      OpAdd, OpSub, OpAnd, OpOr, OpXor: w_legal = 1'b1;
`ifdef STAGE4_ALU_SHIFT_EN
      OpShl, OpShr: w_legal = 1'b1;
`endif
      default: w_legal = 1'b0;
    endcase
  end

  // Byte datapath; shifts take A straight from the read port since RD_B is skipped.
  always_comb begin
    w_a    = w_is_shift ? reg_read_data : r_a;
    w_sum  = '0;
    w_res  = '0;
    w_cout = 1'b0;
    case (r_oper)
      OpAdd: begin
        w_sum  = {1'b0, w_a} + {1'b0, reg_read_data} + {8'd0, r_carry};
        w_res  = w_sum[7:0];
        w_cout = w_sum[8];
      end
      OpSub: begin
        w_sum  = {1'b0, w_a} + {1'b0, ~reg_read_data} + {8'd0, r_carry};
        w_res  = w_sum[7:0];
        w_cout = w_sum[8];
      end
      OpAnd: w_res = w_a & reg_read_data;
      OpOr:  w_res = w_a | reg_read_data;
      OpXor: w_res = w_a ^ reg_read_data;
`ifdef STAGE4_ALU_SHIFT_EN
      OpShl: begin
        w_res  = {w_a[6:0], r_carry};
        w_cout = w_a[7];
      end
      OpShr: begin
        w_res  = {r_carry, w_a[7:1]};
        w_cout = w_a[0];
      end
`endif
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge ram_clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; empty or illegal requests go straight to DONE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_next = (!w_legal || stage4_length == '0) ? StDone : StRdA;
        end
      end
      StRdA:   w_state_next = w_is_shift ? StWr : StRdB;
      StRdB:   w_state_next = StWr;
      StWr:    w_state_next = w_last ? StDone : StRdA;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Register-file port drive; everything idles at zero outside its own state.
  always_comb begin
    reg_read_address  = '0;
    reg_write         = 1'b0;
    reg_write_address = '0;
    reg_write_data    = '0;
    case (r_state)
      StRdA: reg_read_address = r_src_a + r_idx;
      StRdB: reg_read_address = r_src_b + r_idx;
      StWr: begin
        reg_write         = 1'b1;
        reg_write_address = r_dst + r_idx;
        reg_write_data    = w_res;
      end
      default: ;
    endcase
  end

  // Request latch, operand capture, flag accumulation and index stepping.
  always_ff @(posedge ram_clk or posedge rst) begin
    if (rst) begin
      r_exec_q <= 1'b0;
      r_oper   <= '0;
      r_src_a  <= '0;
      r_src_b  <= '0;
      r_dst    <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_error  <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_exec_q <= stage4_exec;
      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_oper  <= stage4_oper;
            r_src_a <= stage4_src_a;
            r_src_b <= stage4_src_b;
            r_dst   <= stage4_dst;
            r_cnt   <= stage4_length;
            r_ready <= 1'b0;
            r_carry <= w_legal && (stage4_oper == OpSub) && (stage4_length != '0);
            r_zero  <= 1'b1;
            r_error <= ~w_legal;
`ifdef STAGE4_ALU_SHIFT_EN
            r_idx   <= (stage4_oper == OpShr) ? REG_AW'(stage4_length - LEN_W'(1)) : '0;
`else
            r_idx   <= '0;
`endif
          end
        end
        StRdB: r_a <= reg_read_data;
        StWr: begin
          r_carry <= w_cout;
          r_zero  <= r_zero & (w_res == 8'h00);
          r_cnt   <= r_cnt - LEN_W'(1);
          r_idx   <= w_desc ? (r_idx - REG_AW'(1)) : (r_idx + REG_AW'(1));
        end
        StDone: r_ready <= 1'b1;
        default: ;
      endcase
    end
  end

  assign stage4_exec_ready = r_ready;
  assign stage4_carry      = r_carry;
  assign stage4_zero       = r_zero;
  assign stage4_error      = r_error;

endmodule

// File: tb/tb_stage4_alu_seq.sv
// Testbench for stage4_alu_seq: register-file model, directed vector table, hand-written
// corner sequences and randomized operations checked against a byte-loop reference model.
module tb_stage4_alu_seq;

`ifdef STAGE4_ALU_SHIFT_EN
  localparam bit ShiftEn = 1'b1;
`else
  localparam bit ShiftEn = 1'b0;
`endif

  logic       ram_clk;
  logic       rst;
  logic       stage4_exec;
  logic       stage4_exec_ready;
  logic [4:0] stage4_oper;
  logic [5:0] stage4_src_a, stage4_src_b, stage4_dst;
  logic [6:0] stage4_length;
  logic [5:0] reg_read_address;
  logic [7:0] reg_read_data;
  logic       reg_write;
  logic [5:0] reg_write_address;
  logic [7:0] reg_write_data;
  logic       stage4_carry, stage4_zero, stage4_error;

  logic [7:0] mem      [64];
  logic [7:0] tb_image [64];
  logic [7:0] ref_img  [64];
  logic       tb_load;
  int         wr_total = 0;

  int n_checks = 0;
  int n_errors = 0;

  stage4_alu_seq dut (
    .ram_clk           (ram_clk),
    .rst               (rst),
    .stage4_exec       (stage4_exec),
    .stage4_exec_ready (stage4_exec_ready),
    .stage4_oper       (stage4_oper),
    .stage4_src_a      (stage4_src_a),
    .stage4_src_b      (stage4_src_b),
    .stage4_dst        (stage4_dst),
    .stage4_length     (stage4_length),
    .reg_read_address  (reg_read_address),
    .reg_read_data     (reg_read_data),
    .reg_write         (reg_write),
    .reg_write_address (reg_write_address),
    .reg_write_data    (reg_write_data),
    .stage4_carry      (stage4_carry),
    .stage4_zero       (stage4_zero),
    .stage4_error      (stage4_error)
  );

  initial begin
    ram_clk = 1'b0;
    forever #5 ram_clk = ~ram_clk;
  end

  // Register file: synchronous read, bench-side bulk load, DUT write strobe.
  always @(posedge ram_clk) begin
    if (tb_load) begin
      mem <= tb_image;
    end else if (reg_write) begin
      mem[reg_write_address] <= reg_write_data;
      wr_total <= wr_total + 1;
    end
    reg_read_data <= mem[reg_read_address];
  end

  typedef struct packed {
    logic [4:0]      op;
    logic [5:0]      sa;
    logic [5:0]      sb;
    logic [5:0]      d;
    logic [6:0]      n;
    logic [3:0][5:0] pa;
    logic [3:0][7:0] pd;
    logic [2:0][5:0] ea;
    logic [2:0][7:0] ed;
    logic            cz;
    logic            ec;
    logic            ez;
    logic            ee;
    logic [7:0]      elat;
    logic [7:0]      ewr;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mem();
    @(negedge ram_clk);
    tb_load = 1'b1;
    @(negedge ram_clk);
    tb_load = 1'b0;
  endtask

  // Start one operation and count edges from the start edge until ready is seen.
  task automatic run_op(input logic [4:0] op, input logic [5:0] sa, input logic [5:0] sb,
                        input logic [5:0] d, input logic [6:0] n, input bit poke,
                        output int lat, output int wrs);
    int w0;
    bit done;
    @(negedge ram_clk);
    stage4_oper   = op;
    stage4_src_a  = sa;
    stage4_src_b  = sb;
    stage4_dst    = d;
    stage4_length = n;
    stage4_exec   = 1'b1;
    w0 = wr_total;
    @(posedge ram_clk);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 600) begin
      @(negedge ram_clk);
      stage4_exec = 1'b0;
      if (stage4_exec_ready) begin
        done = 1'b1;
      end else begin
        if (poke && lat == 2) begin
          stage4_exec   = 1'b1;
          stage4_oper   = 5'd5;
          stage4_dst    = d + 6'd1;
          stage4_length = 7'd1;
        end
        @(posedge ram_clk);
        lat++;
      end
    end
    check("ready_timeout", int'(done), 1);
    wrs = wr_total - w0;
  endtask

  // Reference: byte-sequential semantics over an array, plain integer arithmetic.
  task automatic model_op(input logic [4:0] op, input logic [5:0] sa, input logic [5:0] sb,
                          input logic [5:0] d, input logic [6:0] n,
                          output int ec, output int ez, output int ee,
                          output int elat, output int ewr);
    int c, a, b, r, idx, nn;
    bit legal, shift;
    nn    = int'(n);
    shift = (op == 5'd6) || (op == 5'd7);
    legal = (op >= 5'd1 && op <= 5'd5) || (ShiftEn && shift);
    ec = 0; ez = 1; ee = legal ? 0 : 1; elat = 1; ewr = 0;
    if (!legal || nn == 0) return;
    c = (op == 5'd2) ? 1 : 0;
    for (int k = 0; k < nn; k++) begin
      idx = (op == 5'd7) ? (nn - 1 - k) : k;
      a = int'(ref_img[(int'(sa) + idx) % 64]);
      b = int'(ref_img[(int'(sb) + idx) % 64]);
      r = 0;
      case (op)
        5'd1: begin r = (a + b + c) % 256;       c = (a + b + c) / 256;       end
        5'd2: begin r = (a + 255 - b + c) % 256; c = (a + 255 - b + c) / 256; end
        5'd3: r = a & b;
        5'd4: r = a | b;
        5'd5: r = a ^ b;
        5'd6: begin r = (a * 2 + c) % 256; c = a / 128; end
        5'd7: begin r = a / 2 + c * 128;   c = a % 2;   end
        default: ;
      endcase
      ref_img[(int'(d) + idx) % 64] = 8'(r);
      if (r != 0) ez = 0;
    end
    ec   = c;
    elat = shift ? (2 * nn + 1) : (3 * nn + 1);
    ewr  = nn;
  endtask

  initial begin
    int lat, wrs, ec, ez, ee, elat, ewr, bad, w0;
    logic [4:0] op;
    logic [5:0] sa, sb, d;
    logic [6:0] n;

    rst = 1'b1;
    tb_load = 1'b0;
    stage4_exec = 1'b0;
    stage4_oper = '0;
    stage4_src_a = '0;
    stage4_src_b = '0;
    stage4_dst = '0;
    stage4_length = '0;
    for (int k = 0; k < 64; k++) tb_image[k] = 8'h00;

    // Directed vectors: op sa sb d n, preload addr/data, expected addr/data, flags, lat, writes.
    vecs[0] = '{5'd1, 6'd0, 6'd2, 6'd4, 7'd2, {6'd3, 6'd2, 6'd1, 6'd0},
                {8'h00, 8'h01, 8'h01, 8'hFF}, {6'd5, 6'd5, 6'd4}, {8'h02, 8'h02, 8'h00},
                1'b1, 1'b0, 1'b0, 1'b0, 8'd7, 8'd2};
    vecs[1] = '{5'd2, 6'd0, 6'd1, 6'd2, 7'd1, {6'd2, 6'd2, 6'd1, 6'd0},
                {8'hAA, 8'hAA, 8'h06, 8'h05}, {6'd2, 6'd2, 6'd2}, {8'hFF, 8'hFF, 8'hFF},
                1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 8'd1};
    vecs[2] = '{5'd2, 6'd0, 6'd1, 6'd2, 7'd1, {6'd2, 6'd2, 6'd1, 6'd0},
                {8'hAA, 8'hAA, 8'h06, 8'h06}, {6'd2, 6'd2, 6'd2}, {8'h00, 8'h00, 8'h00},
                1'b1, 1'b1, 1'b1, 1'b0, 8'd4, 8'd1};
    vecs[3] = '{5'd5, 6'd62, 6'd0, 6'd62, 7'd3, {6'd62, 6'd2, 6'd0, 6'd62},
                {8'h5A, 8'h5A, 8'h5A, 8'h5A}, {6'd0, 6'd63, 6'd62}, {8'h00, 8'h00, 8'h00},
                1'b1, 1'b0, 1'b1, 1'b0, 8'd10, 8'd3};
    vecs[4] = '{5'd1, 6'd0, 6'd1, 6'd2, 7'd0, {6'd2, 6'd2, 6'd1, 6'd0},
                {8'h77, 8'h77, 8'h22, 8'h11}, {6'd2, 6'd2, 6'd2}, {8'h77, 8'h77, 8'h77},
                1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0};
    vecs[5] = '{5'd9, 6'd0, 6'd1, 6'd2, 7'd2, {6'd2, 6'd2, 6'd1, 6'd0},
                {8'h77, 8'h77, 8'h22, 8'h11}, {6'd3, 6'd2, 6'd2}, {8'h00, 8'h77, 8'h77},
                1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0};
    if (ShiftEn) begin
      vecs[6] = '{5'd6, 6'd0, 6'd0, 6'd2, 7'd2, {6'd3, 6'd2, 6'd1, 6'd0},
                  {8'hBB, 8'hAA, 8'h01, 8'h80}, {6'd3, 6'd3, 6'd2}, {8'h03, 8'h03, 8'h00},
                  1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 8'd2};
      vecs[7] = '{5'd7, 6'd0, 6'd0, 6'd2, 7'd2, {6'd3, 6'd2, 6'd1, 6'd0},
                  {8'hBB, 8'hAA, 8'h80, 8'h01}, {6'd3, 6'd3, 6'd2}, {8'h40, 8'h40, 8'h00},
                  1'b1, 1'b1, 1'b0, 1'b0, 8'd5, 8'd2};
    end else begin
      vecs[6] = '{5'd6, 6'd0, 6'd0, 6'd2, 7'd2, {6'd3, 6'd2, 6'd1, 6'd0},
                  {8'hBB, 8'hAA, 8'h01, 8'h80}, {6'd3, 6'd3, 6'd2}, {8'hBB, 8'hBB, 8'hAA},
                  1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0};
      vecs[7] = '{5'd7, 6'd0, 6'd0, 6'd2, 7'd2, {6'd3, 6'd2, 6'd1, 6'd0},
                  {8'hBB, 8'hAA, 8'h80, 8'h01}, {6'd3, 6'd3, 6'd2}, {8'hBB, 8'hBB, 8'hAA},
                  1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0};
    end
    vecs[8] = '{5'd3, 6'd0, 6'd1, 6'd2, 7'd1, {6'd2, 6'd2, 6'd1, 6'd0},
                {8'hAA, 8'hAA, 8'h3C, 8'hF0}, {6'd2, 6'd2, 6'd2}, {8'h30, 8'h30, 8'h30},
                1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 8'd1};
    vecs[9] = '{5'd4, 6'd0, 6'd1, 6'd2, 7'd1, {6'd2, 6'd2, 6'd1, 6'd0},
                {8'hAA, 8'hAA, 8'h0F, 8'hF0}, {6'd2, 6'd2, 6'd2}, {8'hFF, 8'hFF, 8'hFF},
                1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 8'd1};

    // Reset state, while held and after release.
    repeat (2) @(negedge ram_clk);
    for (int p = 0; p < 2; p++) begin
      check("rst_ready", int'(stage4_exec_ready), 0);
      check("rst_write", int'(reg_write), 0);
      check("rst_carry", int'(stage4_carry), 0);
      check("rst_zero", int'(stage4_zero), 0);
      check("rst_error", int'(stage4_error), 0);
      rst = 1'b0;
      @(negedge ram_clk);
    end

    // Table-driven directed vectors.
    for (int v = 0; v < 10; v++) begin
      for (int k = 0; k < 64; k++) tb_image[k] = 8'h00;
      for (int k = 0; k < 4; k++) tb_image[vecs[v].pa[k]] = vecs[v].pd[k];
      load_mem();
      run_op(vecs[v].op, vecs[v].sa, vecs[v].sb, vecs[v].d, vecs[v].n, 1'b0, lat, wrs);
      check($sformatf("v%0d_latency", v), lat, int'(vecs[v].elat));
      check($sformatf("v%0d_writes", v), wrs, int'(vecs[v].ewr));
      check($sformatf("v%0d_error", v), int'(stage4_error), int'(vecs[v].ee));
      if (vecs[v].cz) begin
        check($sformatf("v%0d_carry", v), int'(stage4_carry), int'(vecs[v].ec));
        check($sformatf("v%0d_zero", v), int'(stage4_zero), int'(vecs[v].ez));
      end
      for (int k = 0; k < 3; k++) begin
        check($sformatf("v%0d_mem[%0d]", v, vecs[v].ea[k]), int'(mem[vecs[v].ea[k]]),
              int'(vecs[v].ed[k]));
      end
    end

    // Second exec edge and input changes mid-operation must be ignored.
    for (int k = 0; k < 64; k++) tb_image[k] = 8'h00;
    tb_image[0] = 8'hFF; tb_image[1] = 8'h01; tb_image[2] = 8'h01; tb_image[5] = 8'h99;
    load_mem();
    run_op(5'd1, 6'd0, 6'd2, 6'd4, 7'd2, 1'b1, lat, wrs);
    check("poke_latency", lat, 7);
    check("poke_writes", wrs, 2);
    check("poke_mem4", int'(mem[4]), 8'h00);
    check("poke_mem5", int'(mem[5]), 8'h02);
    repeat (12) @(negedge ram_clk);
    check("poke_no_requeue", wr_total - wrs, wr_total - 2);
    check("poke_idle_ready", int'(stage4_exec_ready), 1);

    // Reset during an operation aborts it after the first write.
    @(negedge ram_clk);
    stage4_oper = 5'd1; stage4_src_a = 6'd0; stage4_src_b = 6'd8;
    stage4_dst = 6'd16; stage4_length = 7'd4; stage4_exec = 1'b1;
    w0 = wr_total;
    @(posedge ram_clk);
    repeat (4) @(posedge ram_clk);
    @(negedge ram_clk);
    rst = 1'b1;
    stage4_exec = 1'b0;
    #1;
    check("midrst_write", int'(reg_write), 0);
    check("midrst_ready", int'(stage4_exec_ready), 0);
    repeat (3) @(negedge ram_clk);
    rst = 1'b0;
    repeat (20) @(negedge ram_clk);
    check("midrst_writes", wr_total - w0, 1);
    check("midrst_ready_after", int'(stage4_exec_ready), 0);

    // Randomized operations against the reference model.
    for (int it = 0; it < 40; it++) begin
      op = 5'($urandom_range(0, 9));
      sa = 6'($urandom_range(0, 63));
      sb = 6'($urandom_range(0, 63));
      d  = (it % 4 == 0) ? sa : 6'($urandom_range(0, 63));
      n  = (it % 10 == 9) ? 7'd64 : 7'($urandom_range(0, 9));
      for (int k = 0; k < 64; k++) begin
        tb_image[k] = 8'($urandom_range(0, 255));
        ref_img[k]  = tb_image[k];
      end
      load_mem();
      model_op(op, sa, sb, d, n, ec, ez, ee, elat, ewr);
      run_op(op, sa, sb, d, n, 1'b0, lat, wrs);
      bad = 0;
      for (int k = 0; k < 64; k++) if (mem[k] !== ref_img[k]) bad++;
      check($sformatf("rnd%0d_op%0d_n%0d_mem_bad_bytes", it, op, n), bad, 0);
      check($sformatf("rnd%0d_latency", it), lat, elat);
      check($sformatf("rnd%0d_writes", it), wrs, ewr);
      check($sformatf("rnd%0d_error", it), int'(stage4_error), ee);
      if (ee == 0) begin
        check($sformatf("rnd%0d_carry", it), int'(stage4_carry), ec);
        check($sformatf("rnd%0d_zero", it), int'(stage4_zero), ez);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
